// File: rtl/tsg_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tsg_seq_ctrl_pkg
// Shared definitions for the test-syndrome-generator sequencer: the FSM state
// encoding and the default pattern-count parameters.
// ---------------------------------------------------------------------------
package tsg_seq_ctrl_pkg;

    // HD pattern plus three gray-stepped test patterns
    localparam int NUM_TP_DEF = 4;
    localparam int IDX_W_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_STEP    = 3'd3,
        ST_DONE    = 3'd4
    } tsg_state_e;

endpackage

// File: rtl/tsg_pattern_cnt.sv
// ---------------------------------------------------------------------------
// tsg_pattern_cnt
// Index of the test-syndrome set currently held by the TSG.
// Clear has priority over increment; the count saturates at NUM_TP-1.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   clr      in   synchronous clear to 0
//   inc      in   advance by one (ignored at NUM_TP-1)
//   cnt      out  current index
//   is_last  out  cnt == NUM_TP-1
// ---------------------------------------------------------------------------
module tsg_pattern_cnt #(
    parameter int NUM_TP = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] cnt,
    output logic             is_last
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TP - 1);

    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign is_last = (cnt_q == LAST);

endmodule

// File: rtl/tsg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tsg_seq_ctrl
// Sequencer for the 3-case test syndrome generator of the Chase-style BCH
// decoder. On start it strobes the TSG init (load HD syndromes), then offers
// each test-syndrome set to the key-equation stage over valid/ready, pulsing
// the TSG step enable between sets, and pulses done after the last set.
// Ports:
//   clk             in   rising-edge clock
//   in_ctr_Arst     in   asynchronous active-high reset
//   in_ctr_start    in   request a new codeword run (honoured only in IDLE)
//   in_ctr_abort    in   synchronous abort back to IDLE (beats start/ready)
//   in_ready        in   downstream accepts the presented set
//   out_ctr_en      out  TSG global enable (INIT and STEP)
//   out_ctr_init    out  TSG init strobe
//   out_ctr_TSG_en  out  TSG step strobe
//   out_valid       out  a test-syndrome set is presented
//   out_tp_idx      out  index of the presented set (0 = HD syndromes)
//   out_last        out  presented set is the final one
//   out_busy        out  sequencer not idle
//   out_done        out  one-cycle pulse after the last set is accepted
// ---------------------------------------------------------------------------
module tsg_seq_ctrl
    import tsg_seq_ctrl_pkg::*;
#(
    parameter int NUM_TP = NUM_TP_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             in_ctr_Arst,
    input  logic             in_ctr_start,
    input  logic             in_ctr_abort,
    input  logic             in_ready,
    output logic             out_ctr_en,
    output logic             out_ctr_init,
    output logic             out_ctr_TSG_en,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_tp_idx,
    output logic             out_last,
    output logic             out_busy,
    output logic             out_done
);

    tsg_state_e state_q, state_d;

    logic en_q, en_d;
    logic init_q, init_d;
    logic tsg_en_q, tsg_en_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic idx_clr;
    logic idx_inc;
    logic idx_is_last;

    // Next state plus index control. Abort wins over everything outside IDLE.
    always_comb begin
        state_d = state_q;
        idx_clr = 1'b0;
        idx_inc = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                idx_clr = 1'b1;
                if (in_ctr_start && !in_ctr_abort) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                idx_clr = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (in_ready) begin
                    state_d = idx_is_last ? ST_DONE : ST_STEP;
                end
            end
            ST_STEP: begin
                // The TSG advances on the same edge, so idx and syndromes stay aligned
                idx_inc = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_DONE: begin
                idx_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                idx_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (in_ctr_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_clr = 1'b1;
            idx_inc = 1'b0;
        end
    end

    // Moore outputs decoded from the next state so they are registered and
    // line up with the state they describe.
    always_comb begin
        init_d   = (state_d == ST_INIT);
        tsg_en_d = (state_d == ST_STEP);
        en_d     = init_d | tsg_en_d;
        valid_d  = (state_d == ST_PRESENT);
        done_d   = (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge in_ctr_Arst) begin
        if (in_ctr_Arst) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            init_q   <= 1'b0;
            tsg_en_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            init_q   <= init_d;
            tsg_en_q <= tsg_en_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    tsg_pattern_cnt #(
        .NUM_TP (NUM_TP),
        .IDX_W  (IDX_W)
    ) u_pattern_cnt (
        .clk     (clk),
        .rst     (in_ctr_Arst),
        .clr     (idx_clr),
        .inc     (idx_inc),
        .cnt     (out_tp_idx),
        .is_last (idx_is_last)
    );

    assign out_ctr_en     = en_q;
    assign out_ctr_init   = init_q;
    assign out_ctr_TSG_en = tsg_en_q;
    assign out_valid      = valid_q;
    assign out_busy       = busy_q;
    assign out_done       = done_q;
    assign out_last       = valid_q & idx_is_last;

endmodule

// File: tb/tb_tsg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tsg_seq_ctrl
// Bench for the TSG sequencer. The reference model views a run as a linear
// schedule of slots: slot 0 = init, odd slot 2i+1 = set i presented,
// even slot 2i+2 = step after set i, slot 2*NUM_TP = done. Every slot lasts
// one cycle except presentation slots, which advance only on ready.
// A small behavioural TSG driven by the DUT strobes provides syndromes that
// are compared with HD XOR the gray-code pattern alphas of the shown index.
// ---------------------------------------------------------------------------
module tb_tsg_seq_ctrl;

    localparam int NUM_TP = 4;
    localparam int IDX_W  = 2;
    localparam int S_DONE = 2 * NUM_TP;

    logic             clk = 1'b0;
    logic             in_ctr_Arst;
    logic             in_ctr_start;
    logic             in_ctr_abort;
    logic             in_ready;
    logic             out_ctr_en;
    logic             out_ctr_init;
    logic             out_ctr_TSG_en;
    logic             out_valid;
    logic [IDX_W-1:0] out_tp_idx;
    logic             out_last;
    logic             out_busy;
    logic             out_done;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit m_busy = 1'b0;
    int m_s    = 0;

    // behavioural TSG
    logic [15:0] hd_syn = 16'h0;
    logic [15:0] tsg_syn = 16'h0;
    int          tsg_cnt = 0;
    logic [15:0] alpha [2] = '{16'h3A51, 16'h0C97};

    always #5 clk = ~clk;

    tsg_seq_ctrl #(
        .NUM_TP (NUM_TP),
        .IDX_W  (IDX_W)
    ) dut (
        .clk            (clk),
        .in_ctr_Arst    (in_ctr_Arst),
        .in_ctr_start   (in_ctr_start),
        .in_ctr_abort   (in_ctr_abort),
        .in_ready       (in_ready),
        .out_ctr_en     (out_ctr_en),
        .out_ctr_init   (out_ctr_init),
        .out_ctr_TSG_en (out_ctr_TSG_en),
        .out_valid      (out_valid),
        .out_tp_idx     (out_tp_idx),
        .out_last       (out_last),
        .out_busy       (out_busy),
        .out_done       (out_done)
    );

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    function automatic logic [15:0] alpha_sum(input int g);
        logic [15:0] acc = 16'h0;
        for (int b = 0; b < 2; b++) begin
            if (((g >> b) & 1) != 0) acc = acc ^ alpha[b];
        end
        return acc;
    endfunction

    // TSG: init loads HD and rewinds the gray counter; each step flips the
    // one LRP whose gray bit changes.
    always @(posedge clk) begin
        if (out_ctr_init) begin
            tsg_syn <= hd_syn;
            tsg_cnt <= 0;
        end else if (out_ctr_TSG_en) begin
            tsg_syn <= tsg_syn ^ alpha_sum(gray(tsg_cnt) ^ gray(tsg_cnt + 1));
            tsg_cnt <= tsg_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit st, input bit ab, input bit rd);
        if (!m_busy) begin
            if (st && !ab) begin
                m_busy = 1'b1;
                m_s    = 0;
                hd_syn = 16'($urandom);
            end
        end else if (ab) begin
            m_busy = 1'b0;
        end else if (m_s == S_DONE) begin
            m_busy = 1'b0;
        end else if ((m_s % 2) == 1) begin
            if (rd) m_s++;
        end else begin
            m_s++;
        end
    endtask

    task automatic check_all();
        bit e_init, e_step, e_valid, e_done, e_last;
        int e_idx;
        e_init  = m_busy && (m_s == 0);
        e_valid = m_busy && ((m_s % 2) == 1);
        e_step  = m_busy && ((m_s % 2) == 0) && (m_s > 0) && (m_s < S_DONE);
        e_done  = m_busy && (m_s == S_DONE);
        if (!m_busy || m_s == 0) e_idx = 0;
        else if (e_valid)        e_idx = (m_s - 1) / 2;
        else if (e_step)         e_idx = (m_s - 2) / 2;
        else                     e_idx = NUM_TP - 1;
        e_last = e_valid && (e_idx == NUM_TP - 1);

        check_val("en",     32'(out_ctr_en),     32'(e_init | e_step));
        check_val("init",   32'(out_ctr_init),   32'(e_init));
        check_val("tsg_en", 32'(out_ctr_TSG_en), 32'(e_step));
        check_val("valid",  32'(out_valid),      32'(e_valid));
        check_val("idx",    32'(out_tp_idx),     32'(e_idx));
        check_val("last",   32'(out_last),       32'(e_last));
        check_val("busy",   32'(out_busy),       32'(m_busy));
        check_val("done",   32'(out_done),       32'(e_done));
        check_val("init_tsg_excl", 32'(out_ctr_init & out_ctr_TSG_en), 32'd0);
        if (e_valid) begin
            check_val("tsg_syn", 32'(tsg_syn), 32'(hd_syn ^ alpha_sum(gray(e_idx))));
        end
    endtask

    // one clock: drive at the falling edge, model at the rising edge, check at the next falling edge
    task automatic cyc(input bit st, input bit ab, input bit rd);
        in_ctr_start = st;
        in_ctr_abort = ab;
        in_ready     = rd;
        @(posedge clk);
        model_step(st, ab, rd);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_until_slot(input int slot, input bit rd);
        int guard = 0;
        while (!(m_busy && m_s == slot) && guard < 50) begin
            cyc(1'b0, 1'b0, rd);
            guard++;
        end
        check_val("reach_slot", 32'(m_busy && m_s == slot), 32'd1);
    endtask

    initial begin
        int n_busy, n_step, done_at;

        in_ctr_Arst  = 1'b1;
        in_ctr_start = 1'b0;
        in_ctr_abort = 1'b0;
        in_ready     = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        in_ctr_Arst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // reset in the middle of presenting set 2
        cyc(1'b1, 1'b0, 1'b1);
        run_until_slot(5, 1'b1);
        in_ready = 1'b0;
        #2 in_ctr_Arst = 1'b1;
        #1;
        m_busy = 1'b0;
        m_s    = 0;
        check_val("rst_busy",  32'(out_busy),  32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_idx",   32'(out_tp_idx), 32'd0);
        check_all();
        @(negedge clk);
        in_ctr_Arst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // full run with ready tied high: timing of init, steps and done
        n_busy = 0; n_step = 0; done_at = 0;
        cyc(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) cyc(1'b0, 1'b0, 1'b1);
            if (c == 1) check_val("init_at_k1", 32'(out_ctr_init), 32'd1);
            if (c == 2) check_val("valid_at_k2", 32'(out_valid), 32'd1);
            if (out_busy) n_busy++;
            if (out_ctr_TSG_en) n_step++;
            if (out_done) done_at = c;
        end
        check_val("busy_cycles", 32'(n_busy),  32'(2 * NUM_TP + 1));
        check_val("step_pulses", 32'(n_step),  32'(NUM_TP - 1));
        check_val("done_cycle",  32'(done_at), 32'(2 * NUM_TP + 1));

        // backpressure at idx 1
        cyc(1'b1, 1'b0, 1'b1);
        run_until_slot(3, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
        check_val("held_idx", 32'(out_tp_idx), 32'd1);
        run_until_slot(S_DONE, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // abort in the step from idx 1 to 2, then a fresh run from idx 0
        cyc(1'b1, 1'b0, 1'b1);
        run_until_slot(4, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check_val("abort_idle", 32'(out_busy), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_val("rerun_idx0", 32'(out_tp_idx), 32'd0);
        run_until_slot(S_DONE, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // start with abort in IDLE; start during PRESENT and DONE
        cyc(1'b1, 1'b1, 1'b0);
        check_val("start_abort_idle", 32'(out_busy), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        run_until_slot(2 * NUM_TP - 1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("start_in_done_ignored", 32'(out_busy), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) == 0, ($urandom % 25) == 0, ($urandom % 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
